// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave EEPROM.
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_ACK_DEV,
        ST_REG_ADDR,
        ST_ACK_REG,
        ST_WRITE,
        ST_ACK_WR,
        ST_READ,
        ST_ACK_RD,
        ST_WAIT_STOP
    } state_t;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'b1010000;

    // SDA level of an acknowledge / not-acknowledge bit on the wire.
    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into clk and derives SCL edge and START/STOP strobes.
// Each line goes through two sync flops plus one history flop; all strobes
// compare the synchronized value against the history value.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    // [0] first sync flop, [1] synchronized value, [2] history
    logic [2:0] scl_pipe;
    logic [2:0] sda_pipe;

    // Shift both lines through the synchronizer; idle bus level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_pipe <= 3'b111;
            sda_pipe <= 3'b111;
        end else begin
            scl_pipe <= {scl_pipe[1:0], scl_in};
            sda_pipe <= {sda_pipe[1:0], sda_in};
        end
    end

    assign sda      = sda_pipe[1];
    assign scl_rise =  scl_pipe[1] & ~scl_pipe[2];
    assign scl_fall = ~scl_pipe[1] &  scl_pipe[2];
    // SDA edges only count as conditions while SCL stays high across both samples.
    assign start    = scl_pipe[1] & scl_pipe[2] & ~sda_pipe[1] &  sda_pipe[2];
    assign stop     = scl_pipe[1] & scl_pipe[2] &  sda_pipe[1] & ~sda_pipe[2];

endmodule

// File: rtl/i2c_slave_eeprom.sv
// I2C slave with a byte-addressed register file (EEPROM-style access).
// Write: START, dev+W, reg, data... STOP. Read: START, dev+R, data... with
// master ACK per byte and NACK on the last. The address pointer auto-increments
// modulo MEM_DEPTH and survives between transactions (current-address read).
// SDA is open-drain: sda_pad_o is tied low and sda_padoen_o=0 pulls the line low.
module i2c_slave_eeprom
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = DEFAULT_DEV_ADDR,
    parameter int         MEM_DEPTH = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_pad_i,
    input  logic       sda_pad_i,
    output logic       sda_pad_o,
    output logic       sda_padoen_o,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output state_t     dbg_state
);

    logic       sda_s;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] pointer;
    logic       rw;
    logic [7:0] mem [MEM_DEPTH];

    logic [7:0] rx_byte;
    logic [7:0] rd_byte;
    logic [7:0] ptr_next;

    i2c_bus_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_pad_i),
        .sda_in   (sda_pad_i),
        .sda      (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start_det),
        .stop     (stop_det)
    );

    // Byte as it will look once the current rising-edge bit is shifted in.
    assign rx_byte   = {shift[6:0], sda_s};
    assign rd_byte   = mem[pointer];
    assign ptr_next  = (pointer == 8'(MEM_DEPTH - 1)) ? 8'd0 : pointer + 8'd1;
    assign sda_pad_o = 1'b0;
    assign dbg_state = state;

    // Storage is not reset; a committed byte lands one clk after its strobe.
    always_ff @(posedge clk) begin
        if (wr_strobe) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Protocol FSM. bit_cnt counts rising edges within a byte; in the ACK
    // states 8 means "waiting for the fall that starts the ACK" and 9 means
    // "ACK driven, waiting for the fall that ends it".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shift        <= '0;
            pointer      <= '0;
            rw           <= 1'b0;
            sda_padoen_o <= 1'b1;
            wr_strobe    <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            if (stop_det) begin
                state        <= ST_IDLE;
                sda_padoen_o <= 1'b1;
                busy         <= 1'b0;
                bit_cnt      <= '0;
            end else if (start_det) begin
                // Also a repeated START: any partial byte is simply dropped.
                state        <= ST_DEV_ADDR;
                sda_padoen_o <= 1'b1;
                bit_cnt      <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_WAIT_STOP: begin
                    end
                    ST_DEV_ADDR: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state <= ST_ACK_DEV;
                                    rw    <= rx_byte[0];
                                    busy  <= 1'b1;
                                end else begin
                                    state <= ST_IDLE;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_REG_ADDR: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                pointer <= rx_byte;
                                state   <= ST_ACK_REG;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= pointer;
                                wr_data   <= rx_byte;
                                pointer   <= ptr_next;
                                state     <= ST_ACK_WR;
                            end
                        end
                    end
                    ST_ACK_DEV, ST_ACK_REG, ST_ACK_WR: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_padoen_o <= ACK_BIT;
                                bit_cnt      <= 4'd9;
                            end else begin
                                bit_cnt <= '0;
                                if (state == ST_ACK_DEV && rw) begin
                                    // Read: the ACK-ending fall also presents the MSB.
                                    state        <= ST_READ;
                                    shift        <= rd_byte;
                                    sda_padoen_o <= rd_byte[7];
                                end else begin
                                    sda_padoen_o <= NACK_BIT;
                                    state        <= (state == ST_ACK_DEV) ? ST_REG_ADDR : ST_WRITE;
                                end
                            end
                        end
                    end
                    ST_READ: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                state   <= ST_ACK_RD;
                                pointer <= ptr_next;
                            end
                        end else if (scl_fall) begin
                            sda_padoen_o <= shift[3'd7 - bit_cnt[2:0]];
                        end
                    end
                    ST_ACK_RD: begin
                        if (scl_fall) begin
                            sda_padoen_o <= NACK_BIT;
                        end else if (scl_rise) begin
                            bit_cnt <= '0;
                            if (sda_s == ACK_BIT) begin
                                // Next byte's MSB goes out on the coming fall (bit_cnt 0).
                                state <= ST_READ;
                                shift <= rd_byte;
                            end else begin
                                state <= ST_WAIT_STOP;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_eeprom.sv
// Bench for i2c_slave_eeprom: bit-banged I2C master, byte-array reference
// memory with a pointer, and a wr_strobe scoreboard fed from the stimulus.
module tb_i2c_slave_eeprom;
    import i2c_slave_pkg::*;

    localparam int Q = 5;                       // quarter SCL period in clks
    localparam logic [6:0] DEV = 7'b1010000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_pad_o;
    logic       sda_padoen_o;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    state_t     dbg_state;

    // Open-drain bus: either side can pull the line low.
    assign sda_line = sda_m & (sda_padoen_o ? 1'b1 : sda_pad_o);

    i2c_slave_eeprom dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scl_pad_i    (scl),
        .sda_pad_i    (sda_line),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o),
        .wr_strobe    (wr_strobe),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model / scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem_m [256];
    bit         valid_m [256];
    int         ptr_m = 0;
    logic [15:0] exp_q[$];      // expected {wr_addr, wr_data}
    logic [7:0]  tx_q[$];       // data bytes for the next write transaction

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Monitor: every committed byte must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && wr_strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected actual=%02h:%02h required=none", wr_addr, wr_data);
            end else begin
                check("wr_strobe", {16'h0, wr_addr, wr_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_w(input logic b);
        sda_m = b; qwait();
        scl = 1'b1; qwait(); qwait();
        scl = 1'b0; qwait();
    endtask

    task automatic bit_r(output logic b);
        sda_m = 1'b1; qwait();
        scl = 1'b1; qwait();
        b = sda_line; qwait();
        scl = 1'b0; qwait();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; qwait();
        scl = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qwait();
        scl = 1'b1; qwait();
        sda_m = 1'b1; qwait(); qwait();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) bit_w(d[i]);
        bit_r(ack);
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) bit_r(d[i]);
        bit_w(master_ack ? ACK_BIT : NACK_BIT);
    endtask

    // Write tx_q starting at reg_a, then STOP.
    task automatic txn_write(input logic [7:0] reg_a);
        logic a;
        i2c_start();
        send_byte({DEV, 1'b0}, a);
        check("ack_dev_w", {31'h0, a}, {31'h0, ACK_BIT});
        check("busy_active", {31'h0, busy}, 32'h1);
        send_byte(reg_a, a);
        check("ack_reg", {31'h0, a}, {31'h0, ACK_BIT});
        ptr_m = reg_a;
        foreach (tx_q[k]) begin
            exp_q.push_back({8'(ptr_m), tx_q[k]});
            mem_m[ptr_m]   = tx_q[k];
            valid_m[ptr_m] = 1'b1;
            ptr_m = (ptr_m + 1) % 256;
            send_byte(tx_q[k], a);
            check("ack_data", {31'h0, a}, {31'h0, ACK_BIT});
        end
        tx_q.delete();
        i2c_stop();
        check("busy_after_stop", {31'h0, busy}, 32'h0);
        check("state_after_stop", 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Read n bytes, optionally setting the pointer first via repeated START.
    task automatic txn_read(input logic set_addr, input logic [7:0] reg_a, input int n);
        logic       a;
        logic [7:0] d;
        if (set_addr) begin
            i2c_start();
            send_byte({DEV, 1'b0}, a);
            check("ack_dev_w", {31'h0, a}, {31'h0, ACK_BIT});
            send_byte(reg_a, a);
            check("ack_reg", {31'h0, a}, {31'h0, ACK_BIT});
            ptr_m = reg_a;
        end
        i2c_start();
        send_byte({DEV, 1'b1}, a);
        check("ack_dev_r", {31'h0, a}, {31'h0, ACK_BIT});
        for (int k = 0; k < n; k++) begin
            recv_byte(k != n - 1, d);
            if (valid_m[ptr_m]) check("rd_data", {24'h0, d}, {24'h0, mem_m[ptr_m]});
            ptr_m = (ptr_m + 1) % 256;
        end
        i2c_stop();
        check("state_after_rd", 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Address byte for some other device: no ACK, slave stays idle.
    task automatic wrong_dev(input logic [7:0] dev_byte);
        logic a;
        i2c_start();
        send_byte(dev_byte, a);
        check("nack_dev", {31'h0, a}, {31'h0, NACK_BIT});
        check("busy_wrong_dev", {31'h0, busy}, 32'h0);
        i2c_stop();
        check("state_wrong_dev", 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       a;
        logic [7:0] wr_reg;
        logic [6:0] bad;
        int         n;

        for (int i = 0; i < 256; i++) valid_m[i] = 1'b0;

        // Reset values
        repeat (4) @(negedge clk);
        check("rst_padoen", {31'h0, sda_padoen_o}, 32'h1);
        check("rst_pad_o", {31'h0, sda_pad_o}, 32'h0);
        check("rst_strobe", {31'h0, wr_strobe}, 32'h0);
        check("rst_wr_addr", {24'h0, wr_addr}, 32'h0);
        check("rst_wr_data", {24'h0, wr_data}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic write then random-access read
        tx_q.push_back(8'h5A);
        txn_write(8'h00);
        txn_read(1'b1, 8'h00, 1);

        // Foreign device address
        wrong_dev(8'hA2);

        // Pointer wrap 0xFF -> 0x00
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        txn_write(8'hFF);
        txn_read(1'b1, 8'hFF, 2);

        // Partial byte aborted by repeated START
        tx_q.push_back(8'h3C);
        txn_write(8'h10);
        i2c_start();
        send_byte({DEV, 1'b0}, a);
        check("ack_dev_abort", {31'h0, a}, {31'h0, ACK_BIT});
        send_byte(8'h10, a);
        check("ack_reg_abort", {31'h0, a}, {31'h0, ACK_BIT});
        ptr_m = 8'h10;
        bit_w(1'b1); bit_w(1'b1); bit_w(1'b0); bit_w(1'b0);
        txn_read(1'b0, 8'h00, 1);

        // Randomized traffic
        for (int it = 0; it < 12; it++) begin
            wr_reg = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom_range(0, 255)));
            txn_write(wr_reg);
            txn_read(1'b1, wr_reg, $urandom_range(1, n));
            if ($urandom_range(0, 1) == 1) txn_read(1'b0, 8'h00, 1);
            if ($urandom_range(0, 3) == 0) begin
                bad = 7'($urandom_range(0, 127));
                if (bad == DEV) bad = bad ^ 7'h01;
                wrong_dev({bad, 1'($urandom_range(0, 1))});
            end
        end

        // Reset while the slave drives a 0 data bit
        tx_q.push_back(8'h00);
        txn_write(8'h30);
        i2c_start();
        send_byte({DEV, 1'b0}, a);
        send_byte(8'h30, a);
        i2c_start();
        send_byte({DEV, 1'b1}, a);
        check("ack_dev_pre_rst", {31'h0, a}, {31'h0, ACK_BIT});
        check("drive_zero_pre_rst", {31'h0, sda_padoen_o}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_release", {31'h0, sda_padoen_o}, 32'h1);
        check("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        scl = 1'b1;
        sda_m = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        repeat (3) @(negedge clk);
        txn_read(1'b0, 8'h00, 1);          // current address after reset is 0
        tx_q.push_back(8'h77);
        txn_write(8'h40);
        txn_read(1'b1, 8'h40, 1);

        // Report
        repeat (4) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
